// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous memory between pcpu fetch, pcpu data and a host load port.
// Per-cycle priority in RUN with a fetch starvation guard; DRAIN/LOAD hand the memory to the host.
module mem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic [DW-1:0] i_rdata,
  output logic          i_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic [DW-1:0] h_rdata,
  output logic          h_rvalid,
  output logic          cpu_hold,
  output logic [AW-1:0] m_addr,
  output logic          m_we,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata
);

  typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_t        r_state;
  logic [3:0]    r_waitCnt;
  logic          r_cpuHold;
  logic          r_iRvalid, r_dRvalid, r_hRvalid;
  logic [DW-1:0] r_iData, r_dData, r_hData;
  logic          w_iGnt, w_dGnt, w_hGnt;

  // Once fetch has been denied MAX_WAIT cycles in a row it outranks data.
  always_comb begin
    w_iGnt = 1'b0;
    w_dGnt = 1'b0;
    w_hGnt = 1'b0;
    if (reset) begin
      case (r_state)
        RUN: begin
          if (i_req && ((r_waitCnt == MaxWait) || !d_req)) w_iGnt = 1'b1;
          else if (d_req)                                  w_dGnt = 1'b1;
        end
        LOAD:    w_hGnt = h_req;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_addr  = '0;
    m_we    = 1'b0;
    m_wdata = '0;
    if (w_hGnt) begin
      m_addr  = h_addr;
      m_we    = h_we;
      m_wdata = h_wdata;
    end else if (w_dGnt) begin
      m_addr  = d_addr;
      m_we    = d_we;
      m_wdata = d_wdata;
    end else if (w_iGnt) begin
      m_addr  = i_addr;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= RUN;
      r_waitCnt <= 4'd0;
      r_cpuHold <= 1'b0;
      r_iRvalid <= 1'b0;
      r_dRvalid <= 1'b0;
      r_hRvalid <= 1'b0;
      r_iData   <= '0;
      r_dData   <= '0;
      r_hData   <= '0;
    end else begin
      r_iRvalid <= w_iGnt;
      r_dRvalid <= w_dGnt & ~d_we;
      r_hRvalid <= w_hGnt & ~h_we;
      if (r_iRvalid) r_iData <= m_rdata;
      if (r_dRvalid) r_dData <= m_rdata;
      if (r_hRvalid) r_hData <= m_rdata;
      case (r_state)
        RUN: begin
          if (w_iGnt)                          r_waitCnt <= 4'd0;
          else if (i_req && r_waitCnt < MaxWait) r_waitCnt <= r_waitCnt + 4'd1;
          if (h_req) begin
            r_state   <= DRAIN;
            r_cpuHold <= 1'b1;
          end
        end
        DRAIN: begin
          r_waitCnt <= 4'd0;
          r_state   <= LOAD;
        end
        LOAD: begin
          r_waitCnt <= 4'd0;
          if (!h_req) begin
            r_state   <= RUN;
            r_cpuHold <= 1'b0;
          end
        end
        default: begin
          r_waitCnt <= 4'd0;
          r_state   <= RUN;
          r_cpuHold <= 1'b0;
        end
      endcase
    end
  end

  // Read data comes straight from memory in the valid cycle and is held afterwards.
  assign i_gnt    = w_iGnt;
  assign d_gnt    = w_dGnt;
  assign h_gnt    = w_hGnt;
  assign i_rvalid = r_iRvalid;
  assign d_rvalid = r_dRvalid;
  assign h_rvalid = r_hRvalid;
  assign i_rdata  = r_iRvalid ? m_rdata : r_iData;
  assign d_rdata  = r_dRvalid ? m_rdata : r_dData;
  assign h_rdata  = r_hRvalid ? m_rdata : r_hData;
  assign cpu_hold = r_cpuHold;

endmodule
